serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor. It computes `a - b - bin` one bit per clock, LSB first, through a single registered borrow stage. It uses a start/ready request handshake and a valid/ack result handshake, and provides the subtraction counterpart to the combinational ripple-carry adder for area-constrained datapaths.

---
 rtl/serial_subtractor.sv | 124 ++++++++++++
 tb/tb_serial_subtractor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
`timescale 1ns/1ps
// serial_subtractor
//   Bit-serial two's-complement subtractor computing (a - b - bin), one bit
//   per clock, LSB first, through a single registered borrow stage.
//
// Ports
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request, accepted on an edge where ready=1
//   a      in   minuend (WIDTH), sampled at acceptance
//   b      in   subtrahend (WIDTH), sampled at acceptance
//   bin    in   borrow-in, sampled at acceptance
//   ready  out  high only while idle
//   diff   out  (a - b - bin) mod 2^WIDTH, updated only on completion
//   bout   out  unsigned borrow-out (a < b + bin)
//   ovf    out  signed overflow of the subtraction
//   valid  out  result available, held until ack
//   ack    in   consumer accepts the result
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             valid,
   input  logic             ack
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] diff_q;
   logic             br_q;
   logic             bout_q;
   logic             ovf_q;
   logic [CW-1:0]    cnt_q;

   logic             bit_d;
   logic             br_d;
   logic [WIDTH-1:0] res_d;
   logic             last_bit;

   // One full-subtractor slice working on the LSBs of the operand shifters.
   always_comb begin
      bit_d    = a_q[0] ^ b_q[0] ^ br_q;
      br_d     = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
      // Result bits enter from the MSB side so that after WIDTH shifts the
      // first (LSB) bit has reached position 0.
      res_d    = {bit_d, res_q[WIDTH-1:1]};
      last_bit = (cnt_q == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         diff_q  <= '0;
         br_q    <= 1'b0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  br_q    <= bin;
                  res_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= RUN;
               end
            end
            RUN: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               br_q  <= br_d;
               res_q <= res_d;
               if (last_bit) begin
                  // On the final bit a_q[0]/b_q[0] are the original operand
                  // MSBs and bit_d is the result MSB.
                  diff_q  <= res_d;
                  bout_q  <= br_d;
                  ovf_q   <= (a_q[0] != b_q[0]) && (bit_d != a_q[0]);
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            DONE: begin
               if (ack) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready = (state_q == IDLE);
   assign valid = (state_q == DONE);
   assign diff  = diff_q;
   assign bout  = bout_q;
   assign ovf   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
`timescale 1ns/1ps
// tb_serial_subtractor
//   Directed-vector bench for serial_subtractor (WIDTH=4). Expected results
//   are hand-computed constants; one line is printed per transaction.
module tb_serial_subtractor;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;
   logic             valid;
   logic             ack;

   int total_cnt;
   int bad_cnt;
   logic [WIDTH-1:0] last_diff;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .ready (ready),
      .diff  (diff),
      .bout  (bout),
      .ovf   (ovf),
      .valid (valid),
      .ack   (ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one operation; checks latency, hold of the old result during RUN,
   // the final result, and optionally acknowledges it.
   task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input logic binv, input logic [WIDTH-1:0] exp_d,
                        input logic exp_b, input logic exp_o, input bit do_ack);
      check("ready_pre", 32'(ready), 32'd1);
      a     = av;
      b     = bv;
      bin   = binv;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("ready_run", 32'(ready), 32'd0);
      for (int i = 1; i <= WIDTH; i++) begin
         tick();
         if (i < WIDTH) begin
            check("valid_early", 32'(valid), 32'd0);
            check("diff_hold", 32'(diff), 32'(last_diff));
         end
      end
      check("valid_lat", 32'(valid), 32'd1);
      check("diff", 32'(diff), 32'(exp_d));
      check("bout", 32'(bout), 32'(exp_b));
      check("ovf", 32'(ovf), 32'(exp_o));
      $display("op a=%0d b=%0d bin=%0d -> diff=%0d bout=%0d ovf=%0d (exp %0d %0d %0d)",
               av, bv, binv, diff, bout, ovf, exp_d, exp_b, exp_o);
      last_diff = exp_d;
      if (do_ack) begin
         ack = 1'b1;
         tick();
         ack = 1'b0;
         check("ready_after_ack", 32'(ready), 32'd1);
         check("valid_after_ack", 32'(valid), 32'd0);
         check("diff_idle_hold", 32'(diff), 32'(exp_d));
      end
   endtask

   initial begin
      total_cnt = 0;
      bad_cnt   = 0;
      last_diff = '0;
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      ack   = 1'b0;

      // Reset state
      repeat (2) tick();
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_bout", 32'(bout), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      rst_n = 1'b1;
      tick();
      $display("reset idle checked");

      // Directed vectors
      do_op(4'd7, 4'd3, 1'b0, 4'd4,  1'b0, 1'b0, 1'b1);
      do_op(4'd3, 4'd5, 1'b0, 4'd14, 1'b1, 1'b0, 1'b1);
      do_op(4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0, 1'b1);
      // Left in DONE so the asynchronous reset has non-zero outputs to clear.
      do_op(4'd8, 4'd1, 1'b0, 4'd7,  1'b0, 1'b1, 1'b0);

      // Asynchronous reset mid-cycle, no clock edge in between
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_valid", 32'(valid), 32'd0);
      check("arst_ready", 32'(ready), 32'd1);
      check("arst_diff", 32'(diff), 32'd0);
      check("arst_bout", 32'(bout), 32'd0);
      check("arst_ovf", 32'(ovf), 32'd0);
      $display("async reset in DONE: diff=%0d valid=%0d ready=%0d", diff, valid, ready);
      last_diff = '0;
      #2;
      rst_n = 1'b1;
      tick();

      // Handshake: start ignored in RUN/DONE, operand changes ignored mid-RUN
      a     = 4'd12;
      b     = 4'd5;
      bin   = 1'b1;
      start = 1'b1;
      tick();                       // E0
      start = 1'b1;
      a     = 4'd0;
      b     = 4'd15;
      bin   = 1'b0;
      tick();                       // E1
      start = 1'b0;
      a     = 4'd3;
      tick();                       // E2
      tick();                       // E3
      check("hs_valid_early", 32'(valid), 32'd0);
      tick();                       // E4
      check("hs_valid", 32'(valid), 32'd1);
      check("hs_diff", 32'(diff), 32'd6);
      check("hs_bout", 32'(bout), 32'd0);
      check("hs_ovf", 32'(ovf), 32'd1);
      start = 1'b1;
      a     = 4'd1;
      b     = 4'd2;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_valid", 32'(valid), 32'd1);
         check("hold_ready", 32'(ready), 32'd0);
         check("hold_diff", 32'(diff), 32'd6);
         check("hold_bout", 32'(bout), 32'd0);
         check("hold_ovf", 32'(ovf), 32'd1);
      end
      // ack together with start: ack returns to IDLE, start is not taken
      ack = 1'b1;
      tick();
      ack   = 1'b0;
      start = 1'b0;
      check("ack_ready", 32'(ready), 32'd1);
      check("ack_valid", 32'(valid), 32'd0);
      tick();
      check("ack_start_ignored", 32'(ready), 32'd1);
      $display("op a=12 b=5 bin=1 with disturbances -> diff=%0d (exp 6)", diff);
      last_diff = 4'd6;
      do_op(4'd5, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);

      // Reset mid-RUN after two bits
      a     = 4'd9;
      b     = 4'd4;
      bin   = 1'b0;
      start = 1'b1;
      tick();                       // E0
      start = 1'b0;
      tick();                       // E1
      tick();                       // E2
      #3;
      rst_n = 1'b0;
      #1;
      check("mrst_ready", 32'(ready), 32'd1);
      check("mrst_valid", 32'(valid), 32'd0);
      check("mrst_diff", 32'(diff), 32'd0);
      #2;
      rst_n = 1'b1;
      last_diff = '0;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("mrst_no_valid", 32'(valid), 32'd0);
      end
      $display("reset mid-RUN: aborted request discarded, ready=%0d", ready);
      do_op(4'd7, 4'd3, 1'b0, 4'd4, 1'b0, 1'b0, 1'b1);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
